// File: rtl/control_unit_pkg.sv
// Shared definitions for the accumulator-machine control unit: FSM state
// encoding, opcode map, ALU pass-through code and the strobe bundle that the
// decoder hands back to the top level.
package control_unit_pkg;

  // Sequencer states. FETCH is the reset state.
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    LOAD_IR = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    HALT    = 3'd6
  } state_t;

  // Opcode map of the instruction register's upper nibble.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_LDM  = 4'hA;
  localparam logic [3:0] OP_STM  = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_RSVD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU code that forwards operand B unchanged; used to load memory data.
  localparam logic [3:0] ALU_PASS_B = 4'h1;

  // Every strobe the control unit drives, grouped so the decoder has a
  // single output and the top level can blank them all at once.
  typedef struct packed {
    logic       load_ir;
    logic       pc_inc;
    logic       pc_load;
    logic       addr_sel;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       load_acc;
    logic       halted;
  } strobes_t;

  // Opcodes executed by the ALU with the immediate field as operand B.
  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SHL, OP_SHR: is_alu_op = 1'b1;
      default:                        is_alu_op = 1'b0;
    endcase
  endfunction

  // Opcodes that do nothing and retire straight out of DECODE.
  function automatic logic is_nop(input logic [3:0] op);
    is_nop = (op == OP_NOP) || (op == OP_RSVD);
  endfunction

  // Opcodes that need a memory access cycle.
  function automatic logic is_mem_op(input logic [3:0] op);
    is_mem_op = (op == OP_LDM) || (op == OP_STM);
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational strobe decoder: maps the current sequencer state and the
// instruction opcode onto the datapath and memory control strobes.
module control_decoder
  import control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       run,
  input  logic       zero_flag,
  output strobes_t   strobes
);

  // Decode strobes for the present state; states not listed keep all strobes low.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // strobe unassigned, which would otherwise infer a latch.
    strobes = '0;
    case (state)
      FETCH: begin
        // Address comes from the PC (addr_sel=0); a fetch is only requested
        // while the machine is allowed to run.
        strobes.mem_read = run;
      end
      LOAD_IR: begin
        strobes.load_ir = 1'b1;
        strobes.pc_inc  = 1'b1;
      end
      DECODE: begin
        // Opcode settles here; nothing is driven while the branch is taken.
      end
      EXEC: begin
        if (is_alu_op(opcode)) begin
          strobes.alu_op      = opcode;
          strobes.alu_src_imm = 1'b1;
          strobes.load_acc    = 1'b1;
        end else if (opcode == OP_JMP) begin
          strobes.pc_load = 1'b1;
        end else if (opcode == OP_JZ) begin
          strobes.pc_load = zero_flag;
        end
      end
      MEM: begin
        strobes.addr_sel  = 1'b1;
        strobes.mem_read  = (opcode == OP_LDM);
        strobes.mem_write = (opcode == OP_STM);
      end
      WB: begin
        // Memory data passes through the ALU into the accumulator.
        strobes.alu_op   = ALU_PASS_B;
        strobes.load_acc = 1'b1;
      end
      HALT: begin
        strobes.halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for a small accumulator machine. Steps each
// instruction through FETCH / LOAD_IR / DECODE / EXEC / MEM / WB, parks in
// HALT, and counts retired instructions modulo 256. Strobes are decoded from
// the state register and opcode by control_decoder.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       load_ir,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       addr_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] alu_op,
  output logic       alu_src_imm,
  output logic       load_acc,
  output logic       halted,
  output logic [7:0] retired
);

  state_t   state;
  strobes_t strobes;
  strobes_t strobes_gated;

  control_decoder u_decoder (
    .state     (state),
    .opcode    (opcode),
    .run       (run),
    .zero_flag (zero_flag),
    .strobes   (strobes)
  );

  // Sequencer state and retired-instruction counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        FETCH: begin
          if (run && mem_ready) state <= LOAD_IR;
        end
        LOAD_IR: begin
          state <= DECODE;
        end
        DECODE: begin
          if (is_nop(opcode)) begin
            state   <= FETCH;
            retired <= retired + 8'd1;
          end else if (opcode == OP_HALT) begin
            state <= HALT;
          end else if (is_mem_op(opcode)) begin
            state <= MEM;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          state   <= FETCH;
          retired <= retired + 8'd1;
        end
        MEM: begin
          // Hold the access until memory acknowledges; a load still needs
          // its write-back cycle, a store is finished here.
          if (mem_ready) begin
            if (opcode == OP_LDM) begin
              state <= WB;
            end else begin
              state   <= FETCH;
              retired <= retired + 8'd1;
            end
          end
        end
        WB: begin
          state   <= FETCH;
          retired <= retired + 8'd1;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // NOTE: the state register alone would leave FETCH's mem_read=run visible
  // while reset is held, so strobes are blanked combinationally by reset;
  // this also drops an in-flight mem_write the instant reset rises.
  assign strobes_gated = reset ? '0 : strobes;

  // Strobe outputs.
  assign load_ir     = strobes_gated.load_ir;
  assign pc_inc      = strobes_gated.pc_inc;
  assign pc_load     = strobes_gated.pc_load;
  assign addr_sel    = strobes_gated.addr_sel;
  assign mem_read    = strobes_gated.mem_read;
  assign mem_write   = strobes_gated.mem_write;
  assign alu_op      = strobes_gated.alu_op;
  assign alu_src_imm = strobes_gated.alu_src_imm;
  assign load_acc    = strobes_gated.load_acc;
  assign halted      = strobes_gated.halted;

  // Strobe combinations that would corrupt memory or the datapath.
  a_mem_excl: assert property (@(posedge clock) disable iff (reset)
    !(mem_read && mem_write));
  a_ir_excl: assert property (@(posedge clock) disable iff (reset)
    !(load_ir && (load_acc || pc_load)));

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed checks of latency, branching, memory
// stalls, reset and counter wrap, then a randomized instruction stream
// scored against an instruction-level reference model.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       load_ir, pc_inc, pc_load, addr_sel, mem_read, mem_write;
  logic [3:0] alu_op;
  logic       alu_src_imm, load_acc, halted;
  logic [7:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int N_RANDOM = 300;

  always #5 clock = ~clock;

  control_unit dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .opcode      (opcode),
    .zero_flag   (zero_flag),
    .mem_ready   (mem_ready),
    .load_ir     (load_ir),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .addr_sel    (addr_sel),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .load_acc    (load_acc),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected architectural effect of one instruction.
  typedef struct {
    logic [3:0] op;
    bit         acc;
    logic [3:0] aop;
    bit         imm;
    bit         pcl;
    bit         wr;
    logic [7:0] ret;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: what each opcode does to the datapath, from the ISA table.
  function automatic exp_t model(input logic [3:0] op, input bit zf, input logic [7:0] ret);
    exp_t e;
    e.op = op; e.acc = 0; e.aop = 4'h0; e.imm = 0; e.pcl = 0; e.wr = 0; e.ret = ret;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD: begin
        e.acc = 1; e.aop = op; e.imm = 1;
      end
      4'hA:    begin e.acc = 1; e.aop = 4'h1; e.imm = 0; end
      4'h8:    e.pcl = 1;
      4'h9:    e.pcl = zf;
      4'hB:    e.wr = 1;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: invariants every cycle, and per-instruction scoring on retire.
  bit         sb_on = 0;
  bit         obs_acc, obs_imm, obs_pcl, obs_wr;
  logic [3:0] obs_aop;
  logic [7:0] prev_ret;

  always @(negedge clock) begin
    check("strobe_exclusion", {mem_read & mem_write, load_ir & (load_acc | pc_load)}, 0);
    if (halted)
      check("halt_quiet", {load_ir, pc_inc, pc_load, mem_read, mem_write, load_acc}, 0);
    if (reset || !sb_on) begin
      prev_ret = retired;
      obs_acc = 0; obs_imm = 0; obs_pcl = 0; obs_wr = 0; obs_aop = 4'h0;
    end else begin
      if (load_ir) begin
        obs_acc = 0; obs_imm = 0; obs_pcl = 0; obs_wr = 0; obs_aop = 4'h0;
      end
      if (load_acc) begin obs_acc = 1; obs_aop = alu_op; obs_imm = alu_src_imm; end
      if (pc_load)   obs_pcl = 1;
      if (mem_write) obs_wr = 1;
      if (retired != prev_ret) begin
        check("sb_retire_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_retired", retired, e.ret);
          check("sb_load_acc", obs_acc, e.acc);
          if (e.acc) begin
            check("sb_alu_op", obs_aop, e.aop);
            check("sb_alu_src_imm", obs_imm, e.imm);
          end
          check("sb_pc_load", obs_pcl, e.pcl);
          check("sb_mem_write", obs_wr, e.wr);
        end
        prev_ret = retired;
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Advance until the DUT is in LOAD_IR, with a bounded wait.
  task automatic wait_load_ir();
    int k = 0;
    do begin
      step();
      k++;
    end while (!load_ir && k < 40);
    check("load_ir_seen", load_ir, 1);
  endtask

  initial begin
    logic [7:0] ret0;
    logic [7:0] model_ret;
    logic [3:0] op;
    bit         zf;
    int         issued;
    int         cyc;

    // Reset state, with run high to show the fetch request is blanked.
    #1 reset = 1'b1;
    run = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    check("reset_strobes", {load_ir, pc_inc, pc_load, addr_sel, mem_read, mem_write,
                            alu_op, alu_src_imm, load_acc, halted}, 0);
    check("reset_retired", retired, 0);

    // LDI latency: FETCH, LOAD_IR, DECODE, EXEC.
    reset = 1'b0;
    #1;
    check("ldi_c1_fetch", {mem_read, addr_sel, load_ir}, 3'b100);
    step();
    check("ldi_c2_load_ir", {load_ir, pc_inc}, 2'b11);
    opcode = 4'h1;
    step();
    check("ldi_c3_decode", {load_ir, pc_inc, pc_load, mem_read, mem_write, load_acc}, 0);
    step();
    check("ldi_c4_exec", {load_acc, alu_op, alu_src_imm}, 6'b1_0001_1);
    step();
    check("ldi_retired", retired, 1);

    // JZ taken then not taken.
    wait_load_ir();
    opcode = 4'h9;
    zero_flag = 1'b1;
    step();
    step();
    check("jz_taken", pc_load, 1);
    wait_load_ir();
    zero_flag = 1'b0;
    step();
    step();
    check("jz_not_taken", pc_load, 0);

    // LDM with three stalled MEM cycles.
    wait_load_ir();
    opcode = 4'hA;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ldm_mem_hold", {mem_read, addr_sel, mem_write, load_acc}, 4'b1100);
      if (i == 3) mem_ready = 1'b1;
    end
    step();
    check("ldm_wb", {load_acc, alu_src_imm, alu_op, mem_read}, 7'b1_0_0001_0);
    step();
    check("ldm_retired", retired, 4);

    // Reset landing in the MEM cycle of a stalled STM.
    wait_load_ir();
    opcode = 4'hB;
    step();
    mem_ready = 1'b0;
    step();
    check("stm_mem_write", {mem_write, addr_sel}, 2'b11);
    #1 reset = 1'b1;
    #1;
    check("stm_reset_async", {mem_write, addr_sel, mem_read}, 0);
    check("stm_reset_retired", retired, 0);
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("post_reset_fetch", {mem_read, halted}, 2'b10);
    step();
    check("post_reset_load_ir", load_ir, 1);
    opcode = 4'h0;

    // 256 NOPs: counter wraps to zero.
    for (int i = 0; i < 256; i++) begin
      if (i != 0) begin
        wait_load_ir();
        opcode = 4'h0;
      end
      step();
      step();
      if (i == 0 || i >= 254) check("nop_retired", retired, (i + 1) % 256);
    end

    // Randomized stream scored by the monitor, ending with HALT.
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_on = 1'b1;
    issued = 0;
    model_ret = 8'd0;
    cyc = 0;
    while (!halted && cyc < 20000) begin
      step();
      cyc++;
      if (load_ir) begin
        zf = bit'($urandom_range(0, 1));
        if (issued < N_RANDOM) begin
          op = 4'($urandom_range(0, 14));
          issued++;
          model_ret = model_ret + 8'd1;
          sb_q.push_back(model(op, zf, model_ret));
        end else begin
          op = 4'hF;
        end
        opcode = op;
        zero_flag = zf;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      run = ($urandom_range(0, 3) != 0);
    end
    check("halt_reached", halted, 1);
    check("sb_drained", sb_q.size(), 0);
    check("random_retired", retired, N_RANDOM % 256);

    // HALT ignores run and mem_ready and stops counting.
    ret0 = retired;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      run = ~i[0];
      step();
      check("halt_hold", {halted, retired}, {1'b1, ret0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have these ports, clock and reset first, in this order:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- run  in  1  permits new instruction fetch
- opcode  in  4  from instruction register opcode output
- zero_flag  in  1  accumulator-zero flag from datapath
- mem_ready  in  1  memory completes current read/write
- load_ir  out  1  drives instruction register LoadIR
- pc_inc  out  1  program counter +1
- pc_load  out  1  program counter <- IR data field
- addr_sel  out  1  0=PC, 1=IR data field as memory address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request (accumulator to memory)
- alu_op  out  4  ALU operation code
- alu_src_imm  out  1  1=IR data field, 0=memory data as ALU operand B
- load_acc  out  1  accumulator write enable
- halted  out  1  high in HALT state
- retired  out  8  retired-instruction counter
REQ-002 Reset SHALL be reset, asynchronous, active-high; the clock SHALL be clock.

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, LOAD_IR, DECODE, EXEC, MEM, WB and HALT; outputs SHALL be decoded from the state register and opcode only.
REQ-004 Opcode map SHALL be: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 JMP, 9 JZ, A LDM, B STM, C SHL, D SHR, E reserved (treated as NOP), F HALT.
REQ-005 FETCH: mem_read=run, addr_sel=0; SHALL go to LOAD_IR when run & mem_ready, else stay.
REQ-006 LOAD_IR: load_ir=1 and pc_inc=1 for exactly one cycle, then DECODE; opcode SHALL be valid from DECODE onward.
REQ-007 DECODE SHALL assert no outputs and branch as follows: NOP/E -> FETCH; HALT -> HALT; LDM/STM -> MEM; all others -> EXEC.
REQ-008 EXEC SHALL last one cycle, then FETCH: ALU ops -> alu_op=opcode, alu_src_imm=1, load_acc=1; JMP -> pc_load=1; JZ -> pc_load=zero_flag.
REQ-009 MEM: addr_sel=1; mem_read=1 for LDM or mem_write=1 for STM; SHALL hold until mem_ready; then LDM -> WB and STM -> FETCH.
REQ-010 WB: alu_op=4'h1 (pass B), alu_src_imm=0, load_acc=1 for one cycle, then FETCH.
REQ-011 HALT SHALL hold halted=1 with all other strobes 0 until reset; run and mem_ready SHALL be ignored.
REQ-012 retired SHALL increment by 1 on exit from EXEC, WB, MEM (STM), or DECODE (NOP/E); it SHALL wrap from 255 to 0; HALT SHALL not count.
REQ-013 mem_read and mem_write SHALL never be high together; load_ir SHALL never coincide with load_acc or pc_load.
REQ-014 Dropping run mid-instruction SHALL NOT stall; it SHALL only block the next FETCH.
REQ-015 Latency: an immediate ALU instruction with mem_ready tied high SHALL take 4 cycles (FETCH, LOAD_IR, DECODE, EXEC).

Reset
REQ-016 Reset SHALL force state=FETCH, retired=0 and all strobe outputs to 0 immediately, including mid-MEM; the first fetch SHALL start on the first clock edge after reset deasserts.

Structure
REQ-017 A shared package SHALL hold the state enumeration, the opcode constants and the ALU pass-B code.
REQ-018 A single sub-module, control_decoder (combinational, from state and opcode to strobes), is natural; the FSM and counter SHALL remain in control_unit.

Verification
REQ-019 LDI 0x5 with run=1 and mem_ready=1 -> load_ir in cycle 2, load_acc with alu_op=1 and alu_src_imm=1 in cycle 4, retired=1.
REQ-020 JZ with zero_flag=1 then zero_flag=0 -> pc_load=1 in the first EXEC, pc_load=0 in the second.
REQ-021 LDM with mem_ready low for 3 cycles in MEM -> mem_read and addr_sel held for 4 cycles, then one WB cycle with load_acc=1 and alu_src_imm=0.
REQ-022 HALT opcode -> halted=1 indefinitely with run=1 and mem_ready=1 toggling; retired unchanged.
REQ-023 Reset asserted during MEM of STM -> mem_write drops asynchronously; after release, FETCH resumes with retired=0.
REQ-024 256 NOPs -> retired wraps to 0; mem_read/mem_write mutual exclusion checked every cycle.
